// File: rtl/timer_counter_if.sv
// Bus-side signals between the system bridge and one timer instance.
// The bridge drives select/address/lanes/data; the timer returns read data and its interrupt.
interface timer_counter_if;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        irq;

  modport master (
    output sel, addr, write_enable, write_data,
    input  read_data, irq
  );

  modport slave (
    input  sel, addr, write_enable, write_data,
    output read_data, irq
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes.
// Writes take effect at the edge, reads are combinational; no backpressure, always ready.
module timer_counter #(
  parameter int COUNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_e               state_q, state_d;
  logic [3:0]           ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 irq_flag_q, irq_flag_d;

  logic                 ctrl_wr;
  logic                 preset_wr;
  logic                 irq_set;
  logic [31:0]          preset_wr_val;

  assign ctrl_wr   = bus.sel && (bus.addr == 2'd0) && (|bus.write_enable);
  assign preset_wr = bus.sel && (bus.addr == 2'd1) && (|bus.write_enable);

  always_comb begin
    preset_wr_val = 32'(preset_q);
    for (int i = 0; i < 4; i++) begin
      if (bus.write_enable[i]) begin
        preset_wr_val[8*i +: 8] = bus.write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    irq_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          count_d = '0;
          irq_set = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        // MODE 2'b1x behaves as one-shot
        if (ctrl_q[2:1] == 2'b01) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes override the FSM's EN clear; a same-cycle flag set beats the write's clear
    if (ctrl_wr) begin
      if (bus.write_enable[0]) ctrl_d = bus.write_data[3:0];
      irq_flag_d = 1'b0;
    end
    if (irq_set) irq_flag_d = 1'b1;
    if (preset_wr) preset_d = COUNT_W'(preset_wr_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (bus.addr)
      2'd0:    bus.read_data = {28'b0, ctrl_q};
      2'd1:    bus.read_data = 32'(preset_q);
      2'd2:    bus.read_data = 32'(count_q);
      default: bus.read_data = 32'b0;
    endcase
  end

  assign bus.irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register table plus hand-timed counting sequences.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  timer_counter_if bus ();

  timer_counter #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic s, input logic [1:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.sel          = s;
    bus.addr         = a;
    bus.write_enable = we;
    bus.write_data   = d;
    tick();
    bus.sel          = 1'b0;
    bus.write_enable = 4'h0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.read_data, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {31'b0, bus.irq}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 2'd1, 4'hF, 32'h0000_0000, 2'd1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 2'd1, 4'h5, 32'hAABB_CCDD, 2'd1, 32'h00BB_00DD};
    vecs[2]  = '{1'b1, 2'd2, 4'hF, 32'h1234_5678, 2'd2, 32'h0000_0000};
    vecs[3]  = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vecs[4]  = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 2'd1, 32'h00BB_00DD};
    vecs[5]  = '{1'b0, 2'd1, 4'hF, 32'h1111_1111, 2'd1, 32'h00BB_00DD};
    vecs[6]  = '{1'b1, 2'd1, 4'hA, 32'h1122_3344, 2'd1, 32'h11BB_33DD};
    vecs[7]  = '{1'b1, 2'd0, 4'hF, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006};
    vecs[8]  = '{1'b1, 2'd0, 4'hE, 32'h0000_000F, 2'd0, 32'h0000_0006};
    vecs[9]  = '{1'b1, 2'd0, 4'h0, 32'h0000_000F, 2'd0, 32'h0000_0006};
    vecs[10] = '{1'b1, 2'd0, 4'h1, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vecs[11] = '{1'b1, 2'd1, 4'h0, 32'hFFFF_FFFF, 2'd1, 32'h11BB_33DD};

    bus.sel = 1'b0; bus.addr = 2'd0; bus.write_enable = 4'h0; bus.write_data = 32'h0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset after activity
    wr(1'b1, 2'd1, 4'hF, 32'h0000_0055);
    wr(1'b1, 2'd0, 4'hF, 32'h0000_0009);
    tick(); tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // register access table
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].sel, vecs[i].addr, vecs[i].we, vecs[i].wd);
      rd($sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].exp);
    end

    // one-shot, PRESET=3
    wr(1'b1, 2'd1, 4'hF, 32'd3);
    wr(1'b1, 2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] exp_cnt;
      tick();
      exp_cnt = (k == 1) ? 32'd0 : 32'(5 - k);
      rd($sformatf("os_count_e%0d", k), 2'd2, exp_cnt);
      chk_irq($sformatf("os_irq_e%0d", k), k == 5);
    end
    tick();
    rd("os_ctrl_after_int", 2'd0, 32'h8);
    chk_irq("os_irq_held", 1'b1);
    tick();
    chk_irq("os_irq_held2", 1'b1);
    wr(1'b1, 2'd0, 4'hF, 32'h8);
    chk_irq("os_irq_cleared", 1'b0);

    // auto-reload, PRESET=2: 1-cycle pulse every 4 cycles
    wr(1'b1, 2'd1, 4'hF, 32'd2);
    wr(1'b1, 2'd0, 4'hF, 32'hB);
    for (int k = 1; k <= 13; k++) begin
      logic [31:0] exp_cnt;
      tick();
      case ((k - 2) % 4)
        0:       exp_cnt = 32'd2;
        1:       exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      if (k == 1) exp_cnt = 32'd0;
      rd($sformatf("ar_count_e%0d", k), 2'd2, exp_cnt);
      chk_irq($sformatf("ar_irq_e%0d", k), (k >= 4) && (k % 4 == 0));
    end
    wr(1'b1, 2'd0, 4'hF, 32'h0);
    tick(); tick();
    rd("ar_stop_count", 2'd2, 32'd2);
    chk_irq("ar_stop_irq", 1'b0);

    // pause at COUNT=5, then re-enable reloads from PRESET
    wr(1'b1, 2'd1, 4'hF, 32'd7);
    wr(1'b1, 2'd0, 4'hF, 32'h1);
    tick(); tick();
    rd("pa_count_e2", 2'd2, 32'd7);
    tick();
    rd("pa_count_e3", 2'd2, 32'd6);
    wr(1'b1, 2'd0, 4'hF, 32'h0);
    rd("pa_count_e4", 2'd2, 32'd5);
    tick();
    rd("pa_frozen1", 2'd2, 32'd5);
    tick();
    rd("pa_frozen2", 2'd2, 32'd5);
    wr(1'b1, 2'd0, 4'hF, 32'h1);
    tick();
    rd("pa_reen_idle", 2'd2, 32'd5);
    tick();
    rd("pa_reload", 2'd2, 32'd7);
    for (int k = 0; k < 6; k++) tick();
    rd("pa_count_f8", 2'd2, 32'd1);
    chk_irq("pa_masked", 1'b0);
    // IM set by a write landing on the flag-set edge: flag set wins
    wr(1'b1, 2'd0, 4'hF, 32'h9);
    rd("pa_count_f9", 2'd2, 32'd0);
    rd("pa_ctrl_f9", 2'd0, 32'h9);
    chk_irq("pa_irq_unmasked", 1'b1);
    tick();
    rd("pa_ctrl_f10", 2'd0, 32'h8);
    chk_irq("pa_irq_f10", 1'b1);
    wr(1'b1, 2'd0, 4'hF, 32'h0);
    chk_irq("pa_irq_clear", 1'b0);

    // PRESET=0 one-shot: irq after 3 edges
    wr(1'b1, 2'd1, 4'hF, 32'd0);
    wr(1'b1, 2'd0, 4'hF, 32'h9);
    tick();
    chk_irq("p0_irq_e1", 1'b0);
    tick();
    chk_irq("p0_irq_e2", 1'b0);
    tick();
    chk_irq("p0_irq_e3", 1'b1);
    wr(1'b1, 2'd0, 4'hF, 32'h0);

    // PRESET=1, MODE=10 behaves as one-shot
    wr(1'b1, 2'd1, 4'hF, 32'd1);
    wr(1'b1, 2'd0, 4'hF, 32'hD);
    tick(); tick();
    chk_irq("m2_irq_e2", 1'b0);
    tick();
    chk_irq("m2_irq_e3", 1'b1);
    tick();
    rd("m2_ctrl_e4", 2'd0, 32'hC);
    chk_irq("m2_irq_e4", 1'b1);
    wr(1'b1, 2'd0, 4'hF, 32'h0);

    // large PRESET, PRESET write mid-count, reset during CNT
    wr(1'b1, 2'd1, 4'hF, 32'hFFFF_FFFF);
    wr(1'b1, 2'd0, 4'hF, 32'h9);
    tick(); tick();
    rd("big_count_e2", 2'd2, 32'hFFFF_FFFF);
    tick();
    rd("big_count_e3", 2'd2, 32'hFFFF_FFFE);
    wr(1'b1, 2'd1, 4'hF, 32'd5);
    rd("big_count_e4", 2'd2, 32'hFFFF_FFFD);
    rd("big_preset_new", 2'd1, 32'd5);
    tick();
    rd("big_count_e5", 2'd2, 32'hFFFF_FFFC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("cnt_rst_count", 2'd2, 32'h0);
    rd("cnt_rst_ctrl", 2'd0, 32'h0);
    chk_irq("cnt_rst_irq", 1'b0);
    tick(); tick();
    rd("cnt_rst_idle", 2'd2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Memory-mapped down-counting timer peripheral sitting directly downstream of the CPU's data-memory port. It sits behind the system bridge. The bridge decodes the CPU byte-address stream into sel/addr and forwards the byte-lane write enables and write data unchanged. The timer returns read data and drives an interrupt request that feeds the CPU `interrupt` input. One instance is used per timer (Timer0, Timer1).

Parameters:
COUNT_W, 32, width of PRESET and COUNT registers (1..32); narrower values are zero-extended on read_data, upper write_data bits ignored.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
sel  input  1  bridge chip-select; write ignored when 0
addr  input  2  word offset (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
write_enable  input  4  byte-lane write enables, bit i covers write_data[8i+7:8i]
write_data  input  32  store data, already lane-aligned by CPU
read_data  output  32  combinational read of register selected by addr (independent of sel)
irq  output  1  interrupt request = irq_flag & CTRL.IM

Behaviour:
- Reset (reset=1 at edge): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Hence read_data(CTRL)=0 and irq=0; reset overrides any concurrent write or count step.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM. Bits [31:4] not stored and read as 0.
- Writes: when sel=1, each lane with write_enable[i]=1 updates that byte of the addressed register at the edge. COUNT and reserved offset are read-only, so writes to them are dropped. write_enable=0000 means no write.
- read_data: addr 0 gives {28'b0,CTRL[3:0]}; 1 gives PRESET; 2 gives COUNT; 3 gives 0. It shows pre-edge values, with no write-through bypass.
- FSM states: IDLE, LOAD, CNT, INT.
- IDLE: if EN=1, go to LOAD; otherwise stay. COUNT is held.
- LOAD: COUNT<=PRESET, then go to CNT.
- CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT>1, COUNT<=COUNT-1. Else (COUNT<=1): COUNT<=0, irq_flag<=1, go to INT.
- INT, MODE one-shot: CTRL.EN<=0, go to IDLE. irq_flag stays 1 until any CTRL write (sel=1, addr=0, any lane enabled), which clears it.
- INT, MODE auto-reload: irq_flag<=0, go to LOAD. This gives an irq pulse of exactly 1 cycle.
- Latency: from the CTRL write edge (EN set, from IDLE) to irq_flag rising is max(PRESET,1)+2 edges.
- Auto-reload period is PRESET+2 cycles for PRESET>=1, and 3 cycles for PRESET=0.
- Simultaneous events:
  - A CTRL write in the same cycle as the INT-state EN clear: the written value wins, including EN.
  - A CTRL write in the cycle irq_flag would be set: the set wins.
  - A PRESET write during CNT does not affect the running COUNT; it is used at the next LOAD.
  - An EN=0 write while in LOAD/INT takes effect the next cycle: CNT then sees EN=0 and goes to IDLE.
- IM only masks irq; irq_flag still sets while IM=0, and irq rises immediately if IM is later set.
- MODE change mid-count takes effect at the next INT decision.

Test Plan:
- Reset: hold reset 2 cycles after arbitrary writes -> all three registers read 0, irq=0, state IDLE.
- One-shot: PRESET=3, write CTRL=0x9 -> COUNT reads 3,2,1,0 on successive edges; irq high exactly 5 edges after the CTRL write edge and stays high; CTRL reads 0x8; next CTRL write 0x0 -> irq low next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> irq 1-cycle pulses every 4 cycles, at least 3 periods; COUNT sequence 2,1,0,(LOAD hold 0),2,...
- Pause and mask: mid-count at COUNT=5, write CTRL EN=0 -> COUNT frozen at 5, next state IDLE. Re-enable -> reload from PRESET, not resume. With IM=0, irq stays 0 at expiry; then setting IM=1 raises irq.
- Byte lanes / read-only: write PRESET=0xAABBCCDD with write_enable=0101 over 0 -> reads 0x00BB00DD; writes to addr 2/3 and writes with sel=0 leave all registers unchanged.
- Boundary: PRESET=0 and PRESET=0xFFFFFFFF one-shot -> irq after 3 edges; large value decrements without wrap. A PRESET write during CNT does not alter COUNT. Reset asserted during CNT -> IDLE next edge, irq 0.
